// File: rtl/mem_burst_scheduler.sv
// Round-robin scheduler sharing one main-memory burst port between NUM_CORES cores.
// A granted core's descriptor is latched in IDLE. The block then issues one header beat
// carrying the burst length, followed by one address beat per word, and ends with a
// one-cycle done pulse.
module mem_burst_scheduler #(
    parameter int unsigned MAIN_MEM_ADDR_WIDTH = 32,
    parameter int unsigned NUM_CORES           = 4,
    parameter int unsigned BURST_WIDTH         = 6
) (
    input  logic                                     w_clock,
    input  logic                                     w_reset,
    input  logic [NUM_CORES-1:0]                     w_req,
    input  logic [NUM_CORES-1:0]                     w_req_rw,
    input  logic [NUM_CORES*MAIN_MEM_ADDR_WIDTH-1:0] w_req_addr,
    input  logic [NUM_CORES*BURST_WIDTH-1:0]         w_req_burst,
    output logic [NUM_CORES-1:0]                     w_grant,
    output logic [NUM_CORES-1:0]                     w_done,
    output logic                                     w_mem_valid,
    input  logic                                     w_mem_ready,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0]           w_addr,
    output logic                                     w_rw,
    output logic [BURST_WIDTH-1:0]                   w_burst,
    output logic                                     w_busy
);

    localparam int unsigned PtrWidth = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StHeader, StXfer, StDone} state_e;

    state_e                         state_q, state_d;
    logic [PtrWidth-1:0]            r_ptr_q, r_ptr_d;
    logic [PtrWidth-1:0]            sel_q, sel_d;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_WIDTH-1:0]         burst_q, burst_d;
    logic                           rw_q, rw_d;
    logic [BURST_WIDTH-1:0]         count_q, count_d;

    logic [PtrWidth-1:0]            scan_sel;
    logic                           scan_found;
    int unsigned                    scan_idx;

    // Round-robin pick: first requester at or after r_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        scan_sel   = r_ptr_q;
        scan_found = 1'b0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            scan_idx = (32'(r_ptr_q) + k) % NUM_CORES;
            if (!scan_found && w_req[PtrWidth'(scan_idx)]) begin
                scan_found = 1'b1;
                scan_sel   = PtrWidth'(scan_idx);
            end
        end
    end

    // Next-state logic; the descriptor is captured only when leaving IDLE.
    always_comb begin
        state_d = state_q;
        r_ptr_d = r_ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        rw_d    = rw_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (scan_found) begin
                    sel_d   = scan_sel;
                    addr_d  = w_req_addr[scan_sel*MAIN_MEM_ADDR_WIDTH +: MAIN_MEM_ADDR_WIDTH];
                    burst_d = w_req_burst[scan_sel*BURST_WIDTH +: BURST_WIDTH];
                    rw_d    = w_req_rw[scan_sel];
                    count_d = '0;
                    // A zero-length burst skips the memory beats entirely.
                    if (w_req_burst[scan_sel*BURST_WIDTH +: BURST_WIDTH] == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                if (w_mem_ready) begin
                    count_d = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (w_mem_ready) begin
                    count_d = count_q + BURST_WIDTH'(1);
                    if (count_q == burst_q - BURST_WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (sel_q == PtrWidth'(NUM_CORES - 1)) begin
                    r_ptr_d = '0;
                end else begin
                    r_ptr_d = sel_q + PtrWidth'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and descriptor registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            state_q <= StIdle;
            r_ptr_q <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            rw_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            r_ptr_q <= r_ptr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            rw_q    <= rw_d;
            count_q <= count_d;
        end
    end

    // Outputs decoded from state only, so they are stable while memory stalls.
    always_comb begin
        w_grant     = '0;
        w_done      = '0;
        w_mem_valid = 1'b0;
        w_addr      = '0;
        w_burst     = '0;
        w_rw        = 1'b0;
        w_busy      = (state_q != StIdle);
        if (state_q != StIdle) begin
            w_grant[sel_q] = 1'b1;
        end
        unique case (state_q)
            StHeader: begin
                w_mem_valid = 1'b1;
                w_addr      = addr_q;
                w_burst     = burst_q;
                w_rw        = rw_q;
            end
            StXfer: begin
                w_mem_valid = 1'b1;
                // Address wraps silently at the top of the address space.
                w_addr      = addr_q + MAIN_MEM_ADDR_WIDTH'(count_q);
                w_rw        = rw_q;
            end
            StDone: begin
                w_done[sel_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Bench for mem_burst_scheduler: a transaction-level model (queue of expected beats per
// grant) is checked every cycle, alongside directed scenarios with literal expectations.
module tb_mem_burst_scheduler;

    localparam int unsigned AW = 32;
    localparam int unsigned NC = 4;
    localparam int unsigned BW = 6;

    logic             w_clock;
    logic             w_reset;
    logic [NC-1:0]    w_req;
    logic [NC-1:0]    w_req_rw;
    logic [NC*AW-1:0] w_req_addr;
    logic [NC*BW-1:0] w_req_burst;
    logic [NC-1:0]    w_grant;
    logic [NC-1:0]    w_done;
    logic             w_mem_valid;
    logic             w_mem_ready;
    logic [AW-1:0]    w_addr;
    logic             w_rw;
    logic [BW-1:0]    w_burst;
    logic             w_busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_burst_scheduler #(
        .MAIN_MEM_ADDR_WIDTH (AW),
        .NUM_CORES           (NC),
        .BURST_WIDTH         (BW)
    ) dut (
        .w_clock     (w_clock),
        .w_reset     (w_reset),
        .w_req       (w_req),
        .w_req_rw    (w_req_rw),
        .w_req_addr  (w_req_addr),
        .w_req_burst (w_req_burst),
        .w_grant     (w_grant),
        .w_done      (w_done),
        .w_mem_valid (w_mem_valid),
        .w_mem_ready (w_mem_ready),
        .w_addr      (w_addr),
        .w_rw        (w_rw),
        .w_burst     (w_burst),
        .w_busy      (w_busy)
    );

    initial begin
        w_clock = 1'b0;
        forever #5 w_clock = ~w_clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int            m_owner;
    int            m_ptr;
    logic          m_rw;
    logic [AW-1:0] q_addr[$];
    logic [BW-1:0] q_burst[$];

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_rw    = 1'b0;
        q_addr.delete();
        q_burst.delete();
    endtask

    task automatic model_step();
        int            sel;
        logic [AW-1:0] base;
        logic [BW-1:0] len;
        if (w_reset) begin
            model_reset();
        end else if (m_owner < 0) begin
            sel = -1;
            for (int k = 0; k < int'(NC); k++) begin
                if (sel < 0 && w_req[(m_ptr + k) % NC]) sel = (m_ptr + k) % NC;
            end
            if (sel >= 0) begin
                m_owner = sel;
                m_rw    = w_req_rw[sel];
                base    = w_req_addr[sel*AW +: AW];
                len     = w_req_burst[sel*BW +: BW];
                if (len != 0) begin
                    q_addr.push_back(base);
                    q_burst.push_back(len);
                    for (int j = 0; j < int'(len); j++) begin
                        q_addr.push_back(base + AW'(j));
                        q_burst.push_back('0);
                    end
                end
            end
        end else if (q_addr.size() > 0) begin
            if (w_mem_ready) begin
                void'(q_addr.pop_front());
                void'(q_burst.pop_front());
            end
        end else begin
            // Beats exhausted: this is the done cycle.
            m_ptr   = (m_owner + 1) % NC;
            m_owner = -1;
        end
    endtask

    task automatic model_compare();
        logic [NC-1:0] e_grant, e_done;
        logic          e_valid, e_rw, e_busy;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_burst;
        e_grant = '0; e_done = '0; e_valid = 0; e_rw = 0; e_addr = '0; e_burst = '0;
        e_busy  = (m_owner >= 0);
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (q_addr.size() > 0) begin
                e_valid = 1'b1;
                e_addr  = q_addr[0];
                e_burst = q_burst[0];
                e_rw    = m_rw;
            end else begin
                e_done[m_owner] = 1'b1;
            end
        end
        n_cmp++;
        if (w_grant !== e_grant || w_done !== e_done || w_mem_valid !== e_valid ||
            w_addr !== e_addr || w_burst !== e_burst || w_rw !== e_rw || w_busy !== e_busy) begin
            n_err++;
            $display("FAIL model @%0t: got g=%b d=%b v=%b a=%h b=%0d rw=%b busy=%b, expected g=%b d=%b v=%b a=%h b=%0d rw=%b busy=%b",
                     $time, w_grant, w_done, w_mem_valid, w_addr, w_burst, w_rw, w_busy,
                     e_grant, e_done, e_valid, e_addr, e_burst, e_rw, e_busy);
        end
    endtask

    // Model advances on the edge, compares on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge w_clock);
            model_step();
            @(negedge w_clock);
            if (w_reset) model_reset();
            model_compare();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge w_clock);
        #1;
    endtask

    task automatic set_desc(input int c, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic rw);
        w_req_addr[c*AW +: AW]  = a;
        w_req_burst[c*BW +: BW] = b;
        w_req_rw[c]             = rw;
    endtask

    logic          bp_ready[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [AW-1:0] bp_addr[7]  = '{32'h2000, 32'h2000, 32'h2000, 32'h2000,
                                   32'h2001, 32'h2001, 32'h2002};
    logic [BW-1:0] bp_burst[7] = '{6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    logic [AW-1:0] wrap_addr[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    initial begin
        w_reset     = 1'b1;
        w_req       = '0;
        w_req_rw    = '0;
        w_req_addr  = '0;
        w_req_burst = '0;
        w_mem_ready = 1'b1;
        cyc();
        cyc();
        chk("reset_grant", w_grant, 0);
        chk("reset_valid", w_mem_valid, 0);
        chk("reset_busy", w_busy, 0);
        w_reset = 1'b0;
        cyc();

        // Single read from core2
        set_desc(2, 32'h100, 6'd4, 1'b1);
        w_req = 4'b0100;
        cyc();
        chk("sr_grant", w_grant, 4'b0100);
        chk("sr_hdr_valid", w_mem_valid, 1);
        chk("sr_hdr_burst", w_burst, 4);
        chk("sr_hdr_addr", w_addr, 32'h100);
        chk("sr_hdr_rw", w_rw, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("sr_beat_addr", w_addr, 32'h100 + 32'(i));
            chk("sr_beat_burst", w_burst, 0);
        end
        cyc();
        chk("sr_done", w_done, 4'b0100);
        chk("sr_done_valid", w_mem_valid, 0);
        w_req = '0;
        cyc();
        chk("sr_idle_busy", w_busy, 0);
        chk("sr_idle_done", w_done, 0);

        // Round-robin from reset: order 0,1,2,3,0
        w_reset = 1'b1;
        cyc();
        w_reset = 1'b0;
        for (int c = 0; c < int'(NC); c++) set_desc(c, 32'h1000 + 32'(c) * 32'h10, 6'd2, 1'b0);
        w_req = 4'hF;
        cyc();
        for (int g = 0; g < 5; g++) begin
            if (g == 4) w_req = '0;
            for (int c = 0; c < 4; c++) begin
                chk("rr_grant", w_grant, 64'(1) << (g % 4));
                if (c == 3) chk("rr_done", w_done, 64'(1) << (g % 4));
                cyc();
            end
            chk("rr_gap_grant", w_grant, 0);
            if (g < 4) cyc();
        end
        cyc();
        chk("rr_end_busy", w_busy, 0);

        // Backpressure: core1 write, burst 3; descriptor changes mid-transfer are ignored
        set_desc(1, 32'h2000, 6'd3, 1'b0);
        w_req = 4'b0010;
        cyc();
        for (int i = 0; i < 7; i++) begin
            w_mem_ready = bp_ready[i];
            if (i == 2) set_desc(1, 32'h9000, 6'd7, 1'b1);
            chk("bp_valid", w_mem_valid, 1);
            chk("bp_addr", w_addr, bp_addr[i]);
            chk("bp_burst", w_burst, bp_burst[i]);
            chk("bp_rw", w_rw, 0);
            cyc();
        end
        chk("bp_done", w_done, 4'b0010);
        w_req       = '0;
        w_mem_ready = 1'b1;
        cyc();

        // Reset mid-transfer at count 2; pointer must return to core0
        set_desc(2, 32'h300, 6'd5, 1'b1);
        w_req = 4'b0100;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rst_pre_addr", w_addr, 32'h302);
        #2;
        w_reset = 1'b1;
        #1;
        chk("rst_async_valid", w_mem_valid, 0);
        chk("rst_async_grant", w_grant, 0);
        chk("rst_async_addr", w_addr, 0);
        chk("rst_async_busy", w_busy, 0);
        w_req = '0;
        cyc();
        w_reset = 1'b0;
        chk("rst_no_done", w_done, 0);
        set_desc(0, 32'h400, 6'd1, 1'b0);
        set_desc(2, 32'h500, 6'd1, 1'b1);
        w_req = 4'b0101;
        cyc();
        chk("rst_next_grant", w_grant, 4'b0001);
        w_req = '0;
        repeat (4) cyc();
        chk("rst_end_busy", w_busy, 0);

        // Zero-length burst on core3
        set_desc(3, 32'hABC, 6'd0, 1'b1);
        w_req = 4'b1000;
        cyc();
        chk("zb_grant", w_grant, 4'b1000);
        chk("zb_done", w_done, 4'b1000);
        chk("zb_valid", w_mem_valid, 0);
        w_req = '0;
        cyc();
        chk("zb_idle_busy", w_busy, 0);
        chk("zb_idle_valid", w_mem_valid, 0);

        // Address wrap
        set_desc(0, 32'hFFFFFFFE, 6'd4, 1'b1);
        w_req = 4'b0001;
        cyc();
        chk("wrap_hdr_addr", w_addr, 32'hFFFFFFFE);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("wrap_addr", w_addr, wrap_addr[i]);
        end
        cyc();
        chk("wrap_done", w_done, 4'b0001);
        w_req = '0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
